// File: rtl/iir_requant.sv
// iir_requant: two-stage requantizer from the Q24.32 filter accumulator format
// down to Q12.16 samples. Stage 1 rounds (half toward +inf) and drops SHIFT
// fractional bits; stage 2 clamps to the output range and flags clipping.
// Both stages use valid/ready handshaking with full-throughput back-pressure.
// Optional feature: define IIR_REQUANT_SATCNT_EN to enable the saturated-sample
// counter on sat_count (otherwise sat_count is tied to 0 and sat_clr is unused).
module iir_requant #(
    parameter int IN_W  = 57,
    parameter int OUT_W = 29,
    parameter int SHIFT = 16
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic signed [IN_W-1:0]  in,
    input  logic                    in_valid,
    output logic                    in_ready,
    output logic signed [OUT_W-1:0] out,
    output logic                    out_sat,
    output logic                    out_valid,
    input  logic                    out_ready,
    input  logic                    sat_clr,
    output logic [15:0]             sat_count
);

    // Width of the rounded value: one guard bit above IN_W, minus dropped bits.
    localparam int R_W = IN_W + 1 - SHIFT;

    localparam logic signed [IN_W:0] RND =
        {{(IN_W - SHIFT + 1){1'b0}}, 1'b1, {(SHIFT - 1){1'b0}}};
    localparam logic signed [R_W-1:0] MAXV =
        {{(R_W - OUT_W + 1){1'b0}}, {(OUT_W - 1){1'b1}}};
    localparam logic signed [R_W-1:0] MINV =
        {{(R_W - OUT_W + 1){1'b1}}, {(OUT_W - 1){1'b0}}};

    // Add half an LSB in IN_W+1 bits (cannot overflow), then arithmetic shift.
    function automatic logic signed [R_W-1:0] round_shift(input logic signed [IN_W-1:0] x);
        logic signed [IN_W:0] w_sum;
        w_sum = $signed({x[IN_W-1], x}) + RND;
        return R_W'(w_sum >>> SHIFT);
    endfunction

    // Clamp to the output range; MSB of the result is the clipped flag.
    function automatic logic [OUT_W:0] sat_clip(input logic signed [R_W-1:0] x);
        if (x > MAXV) begin
            return {1'b1, MAXV[OUT_W-1:0]};
        end else if (x < MINV) begin
            return {1'b1, MINV[OUT_W-1:0]};
        end
        return {1'b0, x[OUT_W-1:0]};
    endfunction

    logic signed [R_W-1:0]  r_data_p1;
    logic                   r_vld_p1;
    logic signed [OUT_W-1:0] r_out_p2;
    logic                   r_sat_p2;
    logic                   r_vld_p2;
    logic                   w_adv_p1;
    logic                   w_adv_p2;
    logic [OUT_W:0]         w_clip_p1;

    // A stage may load when it is empty or the stage after it is draining.
    assign w_adv_p2  = !r_vld_p2 || out_ready;
    assign w_adv_p1  = !r_vld_p1 || w_adv_p2;
    assign in_ready  = w_adv_p1;
    assign w_clip_p1 = sat_clip(r_data_p1);

    assign out       = r_out_p2;
    assign out_sat   = r_sat_p2;
    assign out_valid = r_vld_p2;

    // Stage valid bits advance together; reset discards anything in flight.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_vld_p1 <= 1'b0;
            r_vld_p2 <= 1'b0;
        end else begin
            if (w_adv_p1) r_vld_p1 <= in_valid;
            if (w_adv_p2) r_vld_p2 <= r_vld_p1;
        end
    end

    // ---- stage 1: round and drop fractional bits ----
    always_ff @(posedge clk) begin
        if (w_adv_p1 && in_valid) r_data_p1 <= round_shift(in);
    end

    // ---- stage 2: clamp to output range and record clipping ----
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_out_p2 <= '0;
            r_sat_p2 <= 1'b0;
        end else if (w_adv_p2 && r_vld_p1) begin
            r_out_p2 <= $signed(w_clip_p1[OUT_W-1:0]);
            r_sat_p2 <= w_clip_p1[OUT_W];
        end
    end

`ifdef IIR_REQUANT_SATCNT_EN
    logic [15:0] r_sat_count;

    // Count clipped samples as they leave; clear wins, count sticks at max.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_sat_count <= '0;
        end else if (sat_clr) begin
            r_sat_count <= '0;
        end else if (r_vld_p2 && out_ready && r_sat_p2 && (r_sat_count != 16'hFFFF)) begin
            r_sat_count <= r_sat_count + 16'd1;
        end
    end

    assign sat_count = r_sat_count;
`else
    logic w_unused_sat_clr;
    assign w_unused_sat_clr = sat_clr;
    assign sat_count        = '0;
`endif

endmodule

// File: tb/tb_iir_requant.sv
// tb_iir_requant: directed bench for iir_requant (rounding, clamping,
// back-pressure, async reset and the optional saturation counter).
module tb_iir_requant;

    localparam int IN_W  = 57;
    localparam int OUT_W = 29;
`ifdef IIR_REQUANT_SATCNT_EN
    localparam int SATCNT_ON = 1;
`else
    localparam int SATCNT_ON = 0;
`endif

    logic                    clk;
    logic                    rst_n;
    logic signed [IN_W-1:0]  in;
    logic                    in_valid;
    logic                    in_ready;
    logic signed [OUT_W-1:0] out;
    logic                    out_sat;
    logic                    out_valid;
    logic                    out_ready;
    logic                    sat_clr;
    logic [15:0]             sat_count;

    int n_checks = 0;
    int n_pass   = 0;

    iir_requant dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in        (in),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .out       (out),
        .out_sat   (out_sat),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .sat_clr   (sat_clr),
        .sat_count (sat_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic signed [63:0] obs,
                         input logic signed [63:0] exp);
        n_checks++;
        if (obs !== exp) $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        else n_pass++;
    endtask

    function automatic logic signed [IN_W-1:0] mk(input int k);
        return IN_W'(longint'(k) <<< 16);
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // One isolated sample with out_ready=1: checks 2-cycle latency and result.
    task automatic send_one(input string tag, input logic signed [IN_W-1:0] v,
                            input longint exp_o, input logic exp_s);
        out_ready = 1'b1;
        in        = v;
        in_valid  = 1'b1;
        step();
        in_valid  = 1'b0;
        in        = '0;
        check({tag, "_lat1"}, out_valid, 0);
        step();
        check({tag, "_vld"}, out_valid, 1);
        check({tag, "_out"}, out, exp_o);
        check({tag, "_sat"}, out_sat, exp_s);
        step();
    endtask

    initial begin
        int nxt;
        int got;
        int cyc;
        logic stalled;
        logic signed [OUT_W-1:0] held;
        logic acc;
        logic oxf;

        rst_n     = 1'b0;
        in        = '0;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        sat_clr   = 1'b0;
        #1;
        check("rst_out_valid", out_valid, 0);
        check("rst_out", out, 0);
        check("rst_out_sat", out_sat, 0);
        check("rst_sat_count", sat_count, 0);
        check("rst_in_ready", in_ready, 1);
        #12 rst_n = 1'b1;
        step();

        // Rounding around half an LSB
        send_one("rnd_pos_half", IN_W'(longint'(32'h8000)), 1, 1'b0);
        send_one("rnd_neg_half", IN_W'(-longint'(32'h8000)), 0, 1'b0);
        send_one("rnd_neg_half1", IN_W'(-longint'(32'h8001)), -1, 1'b0);
        send_one("rnd_int", mk(100), 100, 1'b0);

        // Clamping boundaries
        send_one("sat_pos", IN_W'(longint'(1) <<< 44), 64'sh0FFFFFFF, 1'b1);
        send_one("sat_neg", IN_W'(-(longint'(1) <<< 56)), -(longint'(1) <<< 28), 1'b1);
        send_one("edge_max", IN_W'((longint'(1) <<< 44) - (longint'(1) <<< 15) - 1),
                 64'sh0FFFFFFF, 1'b0);

        // Fill with out_ready=0, then simultaneous in and out transfer
        out_ready = 1'b0;
        in_valid  = 1'b1;
        in        = mk(5);
        step();
        check("fill_rdy1", in_ready, 1);
        in = mk(6);
        step();
        check("fill_rdy2", in_ready, 0);
        check("fill_vld", out_valid, 1);
        check("fill_out5", out, 5);
        step();
        check("fill_hold_out", out, 5);
        check("fill_hold_vld", out_valid, 1);
        in        = mk(7);
        out_ready = 1'b1;
        #1;
        check("fill_rdy_comb", in_ready, 1);
        step();
        check("shift_out6", out, 6);
        check("shift_vld", out_valid, 1);
        check("shift_rdy", in_ready, 1);
        in_valid = 1'b0;
        step();
        check("drain_out7", out, 7);
        check("drain_vld7", out_valid, 1);
        step();
        check("drain_empty", out_valid, 0);

        // Stream 0..99 with random back-pressure
        nxt     = 0;
        got     = 0;
        cyc     = 0;
        stalled = 1'b0;
        held    = '0;
        while (got < 100 && cyc < 2000) begin
            out_ready = 1'($urandom_range(0, 1));
            in_valid  = (nxt < 100);
            in        = mk(nxt);
            #1;
            if (stalled) begin
                check("stall_valid", out_valid, 1);
                check("stall_hold", out, held);
            end
            acc = in_valid && in_ready;
            oxf = out_valid && out_ready;
            if (oxf) begin
                check("stream_data", out, got);
                got++;
            end
            stalled = out_valid && !out_ready;
            held    = out;
            @(posedge clk);
            #1;
            if (acc) nxt++;
            cyc++;
        end
        in_valid = 1'b0;
        check("stream_count", got, 100);
        out_ready = 1'b1;
        step();
        check("stream_no_extra", out_valid, 0);

        // Reset between edges with two samples in flight
        out_ready = 1'b0;
        in_valid  = 1'b1;
        in        = mk(8);
        step();
        in = mk(9);
        step();
        in_valid = 1'b0;
        check("pre_rst_vld", out_valid, 1);
        #2 rst_n = 1'b0;
        #1;
        check("async_rst_vld", out_valid, 0);
        check("async_rst_out", out, 0);
        check("async_rst_rdy", in_ready, 1);
        #1 rst_n = 1'b1;
        step();
        out_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            check("post_rst_idle", out_valid, 0);
            step();
        end
        send_one("post_rst", mk(3), 3, 1'b0);

        // Saturation counter
        check("cnt_start", sat_count, 0);
        send_one("cnt_s1", IN_W'(longint'(1) <<< 44), 64'sh0FFFFFFF, 1'b1);
        send_one("cnt_s2", IN_W'(-(longint'(1) <<< 56)), -(longint'(1) <<< 28), 1'b1);
        send_one("cnt_s3", IN_W'(longint'(1) <<< 50), 64'sh0FFFFFFF, 1'b1);
        check("cnt_three", sat_count, SATCNT_ON ? 3 : 0);
        in       = IN_W'(longint'(1) <<< 44);
        in_valid = 1'b1;
        step();
        in_valid = 1'b0;
        step();
        check("cnt4_sat", out_sat, 1);
        sat_clr = 1'b1;
        step();
        sat_clr = 1'b0;
        check("cnt_clr_prio", sat_count, 0);
        step();
        check("cnt_after_clr", sat_count, 0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
